// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and constants for the APB master bridge.
//                - apb_state_e : transfer FSM encoding (IDLE/SETUP/ACCESS)
//                - c_apb_aw/dw : default address/data widths
//                - c_pprot_*   : bit positions inside pprot[2:0]
//                - apb_rsp_t   : response record {rdata, slverr, timeout}
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int c_apb_aw = 32;
    localparam int c_apb_dw = 32;

    // pprot bit positions
    localparam int c_pprot_priv   = 0;
    localparam int c_pprot_nonsec = 1;
    localparam int c_pprot_instr  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [c_apb_dw-1:0] rdata;
        logic                slverr;
        logic                timeout;
    } apb_rsp_t;

    function automatic apb_rsp_t mk_rsp(input logic [c_apb_dw-1:0] rdata,
                                        input logic slverr,
                                        input logic timeout);
        apb_rsp_t r;
        r.rdata   = rdata;
        r.slverr  = slverr;
        r.timeout = timeout;
        return r;
    endfunction

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge_if
//  Description : APB4 bus bundle between the bridge (initiator) and a slave.
//                master modport : drives psel/penable/pwrite/paddr/pwdata/
//                                 pstrb/pprot, samples prdata/pready/pslverr
//                slave  modport : the mirror image
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [2:0]      pprot;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );

endinterface : apb_master_bridge_if
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_bridge
//  Description : APB4 initiator. Turns a valid/ready command channel into
//                APB SETUP/ACCESS transfers and returns a single-entry
//                buffered response (read data, slverr, timeout).
//  Ports       : pclk, presetn         - clock, sync active-low reset
//                cmd_*                 - command channel (valid/ready)
//                rsp_*                 - response channel (valid/ready)
//                apb (master modport)  - APB4 bus
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int AW             = c_apb_aw,
    parameter int DW             = c_apb_dw,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CHECK_ALIGN    = 1
) (
    input  logic            pclk,
    input  logic            presetn,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_strb,
    input  logic [2:0]      cmd_prot,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_slverr,
    output logic            rsp_timeout,

    apb_master_bridge_if.master apb
);

    localparam int c_sw    = DW / 8;
    // Counter must hold TIMEOUT_CYCLES; keep at least one bit when disabled.
    localparam int c_cw    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_to_en = (TIMEOUT_CYCLES != 0);
    localparam logic [c_cw-1:0] c_cnt_max  = '1;
    // Abort on the edge where the count would reach TIMEOUT_CYCLES.
    localparam logic [c_cw-1:0] c_cnt_last =
        (TIMEOUT_CYCLES > 0) ? c_cw'(TIMEOUT_CYCLES - 1) : '0;

    apb_state_e       r_state;
    apb_state_e       w_state_nxt;

    logic             r_pwrite;
    logic [AW-1:0]    r_paddr;
    logic [DW-1:0]    r_pwdata;
    logic [c_sw-1:0]  r_pstrb;
    logic [2:0]       r_pprot;
    logic [c_cw-1:0]  r_cnt;

    logic             r_rsp_valid;
    logic [DW-1:0]    r_rsp_rdata;
    logic             r_rsp_slverr;
    logic             r_rsp_timeout;

    logic             w_psel;
    logic             w_penable;
    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_misalign;
    logic             w_done;
    logic             w_timeout;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // A new command may only enter when the response slot is free or is being
    // drained on this very edge, so the slot is never overwritten.
    assign w_cmd_ready = presetn && (r_state == IDLE) && (!r_rsp_valid || rsp_ready);
    assign w_accept    = cmd_valid && w_cmd_ready;
    assign w_misalign  = (CHECK_ALIGN != 0) && (cmd_addr[1:0] != 2'b00);
    assign w_done      = (r_state == ACCESS) && apb.pready;
    assign w_timeout   = c_to_en && (r_state == ACCESS) && !apb.pready
                         && (r_cnt == c_cnt_last);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and bus control
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        case (r_state)
            IDLE: begin
                // Misaligned commands are answered locally and never reach the bus.
                if (w_accept && !w_misalign) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_psel      = 1'b1;
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (apb.pready || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address/data phase registers: loaded on accept, held until the next one
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
        end else if ((r_state == IDLE) && w_accept && !w_misalign) begin
            r_pwrite <= cmd_write;
            r_paddr  <= cmd_addr;
            r_pwdata <= cmd_wdata;
            r_pstrb  <= cmd_write ? cmd_strb : '0;
            r_pprot  <= cmd_prot;
        end
    end

    // ------------------------------------------------------------------------
    // ACCESS wait counter: cleared on the way into SETUP, saturating
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_cnt <= '0;
        end else if (w_state_nxt == SETUP) begin
            r_cnt <= '0;
        end else if ((r_state == ACCESS) && !apb.pready && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + c_cw'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Single-entry response slot
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_accept && w_misalign) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : apb.prdata;
            r_rsp_slverr  <= apb.pslverr;
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end else if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_ready   = w_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;

    assign apb.psel    = w_psel;
    assign apb.penable = w_penable;
    assign apb.pwrite  = r_pwrite;
    assign apb.paddr   = r_paddr;
    assign apb.pwdata  = r_pwdata;
    assign apb.pstrb   = r_pstrb;
    assign apb.pprot   = r_pprot;

endmodule : apb_master_bridge
`default_nettype wire
